// File: rtl/alu4_pkg.sv
// rtl/alu4_pkg.sv - shared opcodes, command field layout, flag order and FSM states
package alu4_pkg;

  // ALU opcodes, passed through to the external ALU unchanged
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_LT  = 3'b110;
  localparam logic [2:0] ALU_EQ  = 3'b111;

  // cmd_data layout: {use_acc, sel, a, b}
  localparam int CMD_W       = 12;
  localparam int OPND_W      = 4;
  localparam int SEL_W       = 3;
  localparam int CMD_USE_ACC = 11;
  localparam int CMD_SEL_LSB = 8;
  localparam int CMD_A_LSB   = 4;
  localparam int CMD_B_LSB   = 0;

  // rsp_flags bit order: {overflow, carry, zero}
  localparam int FLAG_W     = 3;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_ZERO  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } seq_state_e;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic ovf, input logic carry,
                                                   input logic zero);
    logic [FLAG_W-1:0] f;
    f = '0;
    f[FLAG_OVF]   = ovf;
    f[FLAG_CARRY] = carry;
    f[FLAG_ZERO]  = zero;
    return f;
  endfunction

endpackage

// File: rtl/alu4_cmd_fifo.sv
// rtl/alu4_cmd_fifo.sv - synchronous command FIFO with full/empty and occupancy count
module alu4_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap explicitly at DEPTH-1; count tracks simultaneous push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu4_op_sequencer.sv
// rtl/alu4_op_sequencer.sv - queues ALU commands, drives the ALU one at a time, returns results
module alu4_op_sequencer
  import alu4_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_data,
  output logic [2:0]  alu_sel,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  input  logic [3:0]  alu_result,
  input  logic        alu_overflow,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_result,
  output logic [2:0]  rsp_flags,
  output logic [3:0]  rsp_seq
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  seq_state_e         state_q;
  seq_state_e         state_d;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [CMD_W-1:0]   fifo_dout;
  logic               capture;
  logic [CNT_W-1:0]   cnt_q;
  logic [OPND_W-1:0]  acc_q;
  logic [SEL_W-1:0]   alu_sel_q;
  logic [OPND_W-1:0]  alu_a_q;
  logic [OPND_W-1:0]  alu_b_q;
  logic [OPND_W-1:0]  rsp_result_q;
  logic [FLAG_W-1:0]  rsp_flags_q;
  logic [3:0]         rsp_seq_q;

  // cmd_ready is forced low while reset is asserted so every output reads 0
  assign cmd_ready = rst_n && !fifo_full;

  alu4_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid && cmd_ready),
    .push_data (cmd_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ALU inputs are registered at pop time, so they stay put through HOLD and IDLE
  assign alu_sel    = alu_sel_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_seq    = rsp_seq_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control decode; IDLE costs one bubble cycle between operations
  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    capture   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_W'(ALU_LAT-1)) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load ALU operands on pop, count latency, capture result, step sequence number
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      alu_sel_q    <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_seq_q    <= '0;
    end else begin
      if (fifo_pop) begin
        alu_sel_q <= fifo_dout[CMD_SEL_LSB +: SEL_W];
        alu_b_q   <= fifo_dout[CMD_B_LSB +: OPND_W];
        // acc only changes at capture, so this is the previous operation's result
        alu_a_q   <= fifo_dout[CMD_USE_ACC] ? acc_q : fifo_dout[CMD_A_LSB +: OPND_W];
        cnt_q     <= '0;
      end else if (state_q == DRIVE) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (capture) begin
        rsp_result_q <= alu_result;
        rsp_flags_q  <= pack_flags(alu_overflow, alu_carry, alu_zero);
        acc_q        <= alu_result;
      end
      if ((state_q == HOLD) && rsp_ready) rsp_seq_q <= rsp_seq_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu4_op_sequencer.sv
// tb/tb_alu4_op_sequencer.sv - directed vector bench for alu4_op_sequencer with ALU model
module tb_alu4_op_sequencer;
  import alu4_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_data;
  logic [2:0]  alu_sel;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [3:0]  alu_result;
  logic        alu_overflow;
  logic        alu_carry;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_result;
  logic [2:0]  rsp_flags;
  logic [3:0]  rsp_seq;
  logic [4:0]  alu_sum;

  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  exp_seq;

  typedef struct {
    logic [11:0] cmd;
    logic [3:0]  res;
    logic [2:0]  flg;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  alu4_op_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .alu_sel      (alu_sel),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .rsp_seq      (rsp_seq)
  );

  // Behavioural 4-bit ALU; with ALU_LAT=1 its result is available within the DRIVE cycle
  always_comb begin
    alu_sum      = 5'd0;
    alu_result   = 4'd0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_sel)
      ALU_ADD: begin
        alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = alu_sum[3:0];
        alu_carry    = alu_sum[4];
        alu_overflow = (alu_a[3] == alu_b[3]) && (alu_sum[3] != alu_a[3]);
      end
      ALU_SUB: begin
        alu_sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_result   = alu_sum[3:0];
        alu_carry    = alu_sum[4];
        alu_overflow = (alu_a[3] != alu_b[3]) && (alu_sum[3] != alu_a[3]);
      end
      ALU_NOT: alu_result = ~alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_XOR: alu_result = alu_a ^ alu_b;
      ALU_LT:  alu_result = {3'b000, (alu_a < alu_b)};
      default: alu_result = {3'b000, (alu_a == alu_b)};
    endcase
    alu_zero = (alu_result == 4'd0);
  end

  function automatic logic [11:0] mk(input logic u, input logic [2:0] s,
                                     input logic [3:0] a, input logic [3:0] b);
    return {u, s, a, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the command is taken on the following posedge
  task automatic push(input logic [11:0] d);
    int tries;
    tries     = 0;
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && tries < 40) begin
      @(negedge clk);
      tries++;
    end
    chk("push_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int accepted;
    int stale;
    logic will;
    logic [3:0] v;

    vecs[0]  = '{mk(0, ALU_ADD, 4'b0111, 4'b0001), 4'b1000, 3'b100};
    vecs[1]  = '{mk(0, ALU_SUB, 4'b0011, 4'b0011), 4'b0000, 3'b011};
    vecs[2]  = '{mk(1, ALU_EQ,  4'b1010, 4'b0000), 4'b0001, 3'b000};
    vecs[3]  = '{mk(0, ALU_ADD, 4'b0010, 4'b0011), 4'b0101, 3'b000};
    vecs[4]  = '{mk(1, ALU_ADD, 4'b1111, 4'b0001), 4'b0110, 3'b000};
    vecs[5]  = '{mk(0, ALU_NOT, 4'b0000, 4'b0101), 4'b1010, 3'b000};
    vecs[6]  = '{mk(0, ALU_AND, 4'b1100, 4'b1010), 4'b1000, 3'b000};
    vecs[7]  = '{mk(0, ALU_OR,  4'b1100, 4'b0011), 4'b1111, 3'b000};
    vecs[8]  = '{mk(0, ALU_XOR, 4'b1111, 4'b1111), 4'b0000, 3'b001};
    vecs[9]  = '{mk(0, ALU_LT,  4'b0010, 4'b1001), 4'b0001, 3'b000};
    vecs[10] = '{mk(0, ALU_LT,  4'b1001, 4'b0010), 4'b0000, 3'b001};
    vecs[11] = '{mk(0, ALU_ADD, 4'b1111, 4'b0001), 4'b0000, 3'b011};
    vecs[12] = '{mk(0, ALU_SUB, 4'b0000, 4'b0001), 4'b1111, 3'b000};
    vecs[13] = '{mk(0, ALU_SUB, 4'b1000, 4'b0001), 4'b0111, 3'b110};
    vecs[14] = '{mk(0, ALU_EQ,  4'b0101, 4'b0101), 4'b0001, 3'b000};
    vecs[15] = '{mk(1, ALU_ADD, 4'b0000, 4'b1000), 4'b1001, 3'b000};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 12'd0;
    rsp_ready = 1'b0;
    exp_seq   = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_outputs", {11'd0, alu_sel, alu_a, alu_b, rsp_valid, rsp_result, rsp_flags, rsp_seq}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);

    // Single commands from an empty FIFO: latency, result, flags, sequence number
    for (int i = 0; i < 16; i++) begin
      push(vecs[i].cmd);
      wait_rsp(lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd2);
      chk($sformatf("v%0d_result", i), {28'd0, rsp_result}, {28'd0, vecs[i].res});
      chk($sformatf("v%0d_flags", i), {29'd0, rsp_flags}, {29'd0, vecs[i].flg});
      chk($sformatf("v%0d_seq", i), {28'd0, rsp_seq}, {28'd0, exp_seq});
      consume();
      exp_seq++;
    end

    // Backpressure: 4 buffered plus 1 in flight, then responses in push order
    accepted = 0;
    for (int c = 0; c < 12; c++) begin
      cmd_data  = mk(0, ALU_ADD, 4'(accepted), 4'd1);
      cmd_valid = 1'b1;
      will      = cmd_ready;
      @(negedge clk);
      if (will) accepted++;
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", accepted, 32'd5);
    chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      wait_rsp(lat);
      chk($sformatf("bp%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_result", i), {28'd0, rsp_result}, i + 1);
      chk($sformatf("bp%0d_seq", i), {28'd0, rsp_seq}, {28'd0, exp_seq});
      consume();
      exp_seq++;
    end

    // Reset asserted mid-DRIVE with 3 commands still queued
    push(mk(0, ALU_OR, 4'b0101, 4'b1010));
    wait_rsp(lat);
    for (int i = 0; i < 4; i++) push(mk(0, ALU_XOR, 4'b0110, 4'b0011));
    chk("rd_full", {31'd0, cmd_ready}, 32'd0);
    consume();
    @(negedge clk);
    chk("rd_in_drive", {24'd0, rsp_valid, alu_sel, alu_a}, {24'd0, 1'b0, ALU_XOR, 4'b0110});
    rst_n = 1'b0;
    #1;
    chk("rd_outputs_zero", {10'd0, cmd_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_result, rsp_flags, rsp_seq}, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_seq = 4'd0;
    stale   = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    chk("rd_no_stale_rsp", stale, 32'd0);
    chk("rd_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // 17 commands: sequence number wraps 15 -> 0 without dropping a response
    for (int i = 0; i < 17; i++) begin
      v = 4'(i);
      push(mk(0, ALU_ADD, v, 4'd0));
      wait_rsp(lat);
      chk($sformatf("w%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("w%0d_result", i), {28'd0, rsp_result}, {28'd0, v});
      chk($sformatf("w%0d_flags", i), {29'd0, rsp_flags}, (v == 4'd0) ? 32'd1 : 32'd0);
      chk($sformatf("w%0d_seq", i), {28'd0, rsp_seq}, {28'd0, exp_seq});
      consume();
      exp_seq++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
